// File: rtl/main_memory_responder_pkg.sv
// Shared defaults and helpers for the block-granular main-memory responder.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.

`ifndef MEM_RD_LATENCY
`define MEM_RD_LATENCY 4
`endif
`ifndef MEM_WR_LATENCY
`define MEM_WR_LATENCY 4
`endif
`ifndef MEM_DEPTH_LOG2
`define MEM_DEPTH_LOG2 10
`endif
`ifndef BO_WIDTH
`define BO_WIDTH 4
`endif

package main_memory_responder_pkg;

    localparam int PA_WIDTH_DEF  = 16;
    localparam int BLK_WIDTH_DEF = 128;

    // Busy counter only has to hold latency-1, but never drops below one bit.
    function automatic int cnt_width(input int rd_lat, input int wr_lat);
        int m;
        int w;
        m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/main_memory_responder_mem_block_array.sv
// Block storage: one block per entry, synchronous write, combinational read.
// Latency: write lands on the clock edge; read data follows addr in the same cycle.
// Backpressure: none; the parent sequences all accesses. Contents are never reset.

module mem_block_array #(
    parameter int BLK_WIDTH  = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [BLK_WIDTH-1:0]  wdata,
    output logic [BLK_WIDTH-1:0]  rdata
);

    logic [BLK_WIDTH-1:0] blocks [0:(1<<DEPTH_LOG2)-1];

    // Commit a whole block when the parent raises the write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            blocks[addr] <= wdata;
        end
    end

    assign rdata = blocks[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Responder end of the cache memory port: serves block fills and write-backs (write first on eviction).
// Latency: write WR_LATENCY cycles, read RD_LATENCY cycles, then one DONE cycle with mem_done.
// Backpressure: requests are only sampled in IDLE; mem_busy is high from acceptance through DONE.

`ifndef MEM_RD_LATENCY
`define MEM_RD_LATENCY 4
`endif
`ifndef MEM_WR_LATENCY
`define MEM_WR_LATENCY 4
`endif
`ifndef MEM_DEPTH_LOG2
`define MEM_DEPTH_LOG2 10
`endif
`ifndef BO_WIDTH
`define BO_WIDTH 4
`endif

module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int PA_WIDTH   = PA_WIDTH_DEF,
    parameter int BLK_WIDTH  = BLK_WIDTH_DEF,
    parameter int BO_BITS    = `BO_WIDTH,
    parameter int DEPTH_LOG2 = `MEM_DEPTH_LOG2,
    parameter int RD_LATENCY = `MEM_RD_LATENCY,
    parameter int WR_LATENCY = `MEM_WR_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic [PA_WIDTH-1:0]  mem_wr_addr,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_busy,
    output logic                 mem_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int             CNT_W   = cnt_width(RD_LATENCY, WR_LATENCY);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DEPTH_LOG2-1:0] rd_idx_q;
    logic [DEPTH_LOG2-1:0] wr_idx_q;
    logic [BLK_WIDTH-1:0]  wr_blk_q;
    logic                  rd_pending;

    logic                  accept;
    logic                  cnt_zero;
    logic                  arr_we;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic [BLK_WIDTH-1:0]  arr_rdata;

    // Byte offset and high address bits alias away; fold them into a sink.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr, mem_wr_addr};

    assign accept   = (state == S_IDLE) && (mem_rd_en || mem_wr_en);
    assign cnt_zero = (cnt == '0);

    // The array is single-ported: the victim index owns it while writing, the fill index otherwise.
    assign arr_idx = (state == S_WRITE) ? wr_idx_q : rd_idx_q;
    assign arr_we  = (state == S_WRITE) && cnt_zero && !rst;

    assign mem_busy = (state != S_IDLE);
    assign mem_done = (state == S_DONE);

    // Capture the request once at acceptance so the requester may change its pins afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_idx_q   <= mem_addr[BO_BITS +: DEPTH_LOG2];
            wr_idx_q   <= mem_wr_addr[BO_BITS +: DEPTH_LOG2];
            wr_blk_q   <= mem_wr_blk;
            rd_pending <= mem_rd_en;
        end
    end

    // Request sequencer: write phase first, optional read phase, then a single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            mem_rd_blk <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_wr_en) begin
                        state <= S_WRITE;
                        cnt   <= WR_LOAD;
                    end else if (mem_rd_en) begin
                        state <= S_READ;
                        cnt   <= RD_LOAD;
                    end
                end
                S_WRITE: begin
                    if (cnt_zero) begin
                        if (rd_pending) begin
                            state <= S_READ;
                            cnt   <= RD_LOAD;
                        end else begin
                            state <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (cnt_zero) begin
                        mem_rd_blk <= arr_rdata;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    mem_block_array #(
        .BLK_WIDTH  (BLK_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_idx),
        .wdata (wr_blk_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder with a block-level reference model and scoreboard.
// Latency: expected done cycle per request is derived from the request type and latencies.
// Backpressure: the bench only issues requests while the responder is idle.

module tb_main_memory_responder;

    localparam int RD = 4;
    localparam int WR = 4;

    typedef struct {
        int          lat;
        bit          rd;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wr_addr;
    logic [127:0] mem_wr_blk;
    logic [127:0] mem_rd_blk;
    logic         mem_busy;
    logic         mem_done;

    logic [127:0] model [0:1023];
    logic [127:0] last_rd;
    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    main_memory_responder #(
        .PA_WIDTH   (16),
        .BLK_WIDTH  (128),
        .BO_BITS    (4),
        .DEPTH_LOG2 (10),
        .RD_LATENCY (RD),
        .WR_LATENCY (WR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_blk  (mem_wr_blk),
        .mem_rd_blk  (mem_rd_blk),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done)
    );

    function automatic int idx(input logic [15:0] a);
        return int'(a[13:4]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request in the current (idle) cycle and advance into cycle 1.
    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wa, input logic [127:0] blk);
        exp_t e;
        check(mem_busy, 1'b0, "idle_before_req");
        if (wr) model[idx(wa)] = blk;
        e.lat  = (wr ? WR : 0) + (rd ? RD : 0) + 1;
        e.rd   = rd;
        e.data = rd ? model[idx(addr)] : 128'd0;
        sb.push_back(e);
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_addr    = addr;
        mem_wr_addr = wa;
        mem_wr_blk  = blk;
        tick();
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 16'($urandom);
        mem_wr_addr = 16'($urandom);
        mem_wr_blk  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called in cycle 1; follows the request to DONE, then steps into the next idle cycle.
    task automatic wait_done(input bit junk);
        exp_t e;
        int   n;
        bit   seen;
        e    = sb.pop_front();
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= e.lat + 8) begin
            check(mem_busy, 1'b1, "busy_while_active");
            if (mem_done) begin
                seen = 1'b1;
            end else begin
                if (junk) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_addr = 16'h0090;
                    mem_wr_blk  = {4{32'hBAD0_BAD0}};
                end
                tick();
                n++;
            end
        end
        if (junk) mem_wr_en = 1'b0;
        check(seen, 1'b1, "done_seen");
        if (seen) begin
            check(n, e.lat, "done_cycle");
            check(mem_rd_blk, e.rd ? e.data : last_rd, "rd_blk");
            if (e.rd) last_rd = e.data;
        end
        tick();
        check(mem_done, 1'b0, "done_one_cycle");
        check(mem_busy, 1'b0, "idle_after_done");
    endtask

    initial begin
        rst = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        mem_addr = '0; mem_wr_addr = '0; mem_wr_blk = '0;
        last_rd = '0;
        tick(); tick();
        rst = 1'b0;
        check(mem_busy, 1'b0, "reset_busy");
        check(mem_done, 1'b0, "reset_done");
        check(mem_rd_blk, 128'd0, "reset_rd_blk");

        // Preload index 4 and index 9, then reset: array contents survive reset.
        issue(1'b0, 1'b1, 16'h0, 16'h0040, {32{4'hA, 4'h5}}); wait_done(1'b0);
        issue(1'b0, 1'b1, 16'h0, 16'h0098, {4{32'h0909_0909}}); wait_done(1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        last_rd = '0;
        check(mem_rd_blk, 128'd0, "rst_clears_rd_blk");

        // Plain read of index 4.
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 128'd0); wait_done(1'b0);

        // Write then read with different byte offsets.
        issue(1'b0, 1'b1, 16'h0, 16'h0120, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}); wait_done(1'b0);
        issue(1'b1, 1'b0, 16'h012C, 16'h0, 128'd0); wait_done(1'b0);

        // Eviction to the same block: write lands before the read.
        issue(1'b1, 1'b1, 16'h0200, 16'h0200, {4{32'hDEAD_BEEF}}); wait_done(1'b0);
        // Eviction to different blocks: victim index 33, fill from index 18.
        issue(1'b1, 1'b1, 16'h0120, 16'h0210, {4{32'hC0DE_0021}}); wait_done(1'b0);
        issue(1'b1, 1'b0, 16'h0214, 16'h0, 128'd0); wait_done(1'b0);

        // Enables toggled while busy are ignored; index 9 must stay intact.
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 128'd0); wait_done(1'b1);
        issue(1'b1, 1'b0, 16'h0090, 16'h0, 128'd0); wait_done(1'b0);

        // Read enable held through DONE starts a second request in the following idle cycle.
        issue(1'b1, 1'b0, 16'h0040, 16'h0, 128'd0);
        mem_rd_en = 1'b1; mem_addr = 16'h0120;
        wait_done(1'b0);
        begin
            exp_t e2;
            e2.lat = RD + 1; e2.rd = 1'b1; e2.data = model[idx(16'h0120)];
            sb.push_back(e2);
        end
        tick();
        mem_rd_en = 1'b0;
        wait_done(1'b0);

        // Reset during a write before its commit cycle abandons the write.
        issue(1'b0, 1'b1, 16'h0, 16'h0070, {32{4'h5}}); wait_done(1'b0);
        mem_wr_en = 1'b1; mem_wr_addr = 16'h0070; mem_wr_blk = {32{4'hF}};
        tick();
        mem_wr_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check(mem_busy, 1'b0, "rst_mid_busy");
        check(mem_done, 1'b0, "rst_mid_done");
        check(mem_rd_blk, 128'd0, "rst_mid_rd_blk");
        last_rd = '0;
        issue(1'b1, 1'b0, 16'h0070, 16'h0, 128'd0); wait_done(1'b0);

        // Aliasing above the block index bits.
        issue(1'b0, 1'b1, 16'h0, 16'h4010, {4{32'h0A11_A500}}); wait_done(1'b0);
        issue(1'b1, 1'b0, 16'h0010, 16'h0, 128'd0); wait_done(1'b0);

        // A few random blocks written to indices 32..35 and read back in reverse.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, 16'h0, 16'(16'h0200 + i * 16 + $urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom});
            wait_done(1'b0);
        end
        for (int i = 3; i >= 0; i--) begin
            issue(1'b1, 1'b0, 16'(16'h0200 + i * 16), 16'h0, 128'd0);
            wait_done(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Block-granular main-memory model: the responder end of the cache's memory port. It accepts block fill reads and dirty write-backs from the cache controller and serves each one after a fixed, parameterised latency. A write-back plus fill issued together (eviction) runs write first, then read, and completes with a single `mem_done` pulse. It sits between the cache control unit and the top-level testbench/SoC.

## Interface
- `PA_WIDTH`, 16: physical address width.
- `BLK_WIDTH`, 128: block width in bits (4 × 32-bit words).
- `BO_BITS`, 4: byte-offset bits, log2(BLK_WIDTH/8); ignored on access.
- `DEPTH_LOG2`, 10: number of block address bits; array holds 2^DEPTH_LOG2 blocks.
- `RD_LATENCY`, 4: read busy cycles, ≥1.
- `WR_LATENCY`, 4: write busy cycles, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_rd_en` in 1: fill request.
- `mem_wr_en` in 1: write-back request.
- `mem_addr` in PA_WIDTH: fill (read) address.
- `mem_wr_addr` in PA_WIDTH: write-back (victim) address.
- `mem_wr_blk` in BLK_WIDTH: write-back data.
- `mem_rd_blk` out BLK_WIDTH: fill data, registered.
- `mem_busy` out 1: request in progress.
- `mem_done` out 1: one-cycle completion pulse.

## Operation
- Block index is addr[BO_BITS +: DEPTH_LOG2]. Higher address bits are ignored, so addresses alias modulo 2^DEPTH_LOG2 blocks.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: wr_en=1 → WRITE. Otherwise rd_en=1 → READ. Otherwise stay.
  - On acceptance, latch `mem_addr`, `mem_wr_addr`, `mem_wr_blk`, and a `rd_pending` flag (= rd_en). Inputs are don't-care after acceptance.
  - WRITE: counter loaded with WR_LATENCY−1 and decremented each cycle. On the cycle the counter reaches 0, commit the latched block to the array. Then go to READ if `rd_pending`, else DONE.
  - READ: counter loaded with RD_LATENCY−1. On the cycle it reaches 0, register array[index] into `mem_rd_blk`, then go to DONE.
  - DONE: `mem_done`=1 for this cycle only, then → IDLE. Requests are not sampled in DONE.
- `mem_rd_blk` holds its value until the next read completes. Writes do not change it.
- A read after a write to the same block (including within one eviction) returns the newly written data.
- Reset:
  - `mem_busy`=0, `mem_done`=0, `mem_rd_blk`=0, state=IDLE, counter=0.
  - Array contents are not cleared.
  - Reset mid-operation abandons the request. A write whose commit cycle has not occurred is not performed.
- The requester must drop its enables in the `mem_done` cycle. Enables still high in the following IDLE cycle start a new request.

## Timing
- Cycle 0 is the IDLE cycle in which the request is seen.
- Read only: READ occupies cycles 1..RD_LATENCY; `mem_rd_blk` is valid and `mem_done`=1 in cycle RD_LATENCY+1.
- Write only: write commits in cycle WR_LATENCY; `mem_done` in cycle WR_LATENCY+1.
- Both: write commits in WR_LATENCY; data is valid and `mem_done` is asserted in WR_LATENCY+RD_LATENCY+1.
- `mem_busy` is high from cycle 1 through the DONE cycle inclusive, and low in IDLE.
- Back-to-back: the next request can be seen at earliest in the cycle after DONE.
- Counter width: $clog2(max(RD_LATENCY, WR_LATENCY)), minimum 1.

## Structure
- `macros.v` gains `MEM_RD_LATENCY`, `MEM_WR_LATENCY`, `MEM_DEPTH_LOG2`, and `BO_WIDTH`. Parameter defaults take their values from these macros.
- FSM state encodings are localparams inside the block.
- One sub-module, `mem_block_array`: single-port, 2^DEPTH_LOG2 × BLK_WIDTH, synchronous write enable, combinational read, no reset. Registering is done in the parent.
- The FSM, counter, and request latches live in `main_memory_responder`.

## Test plan
- Reset, then read addr 0x0040 (index 4) with the array preloaded at index 4 to 0xA5…A5 → `mem_done` in cycle 5, `mem_rd_blk`=0xA5…A5, `mem_busy` high cycles 1–5.
- Write 0x1111…_2222 to wr_addr 0x0120 (index 18), then read 0x012C → read returns the written block. Byte-offset bits are ignored.
- Eviction: rd_en=wr_en=1, wr_addr 0x0200 data 0xDEAD…, addr 0x0200 → single `mem_done` in cycle 9, `mem_rd_blk`=0xDEAD…
- Enables held high through DONE → second request accepted in the cycle after DONE. No enables sampled during busy or DONE.
- Assert `rst` in cycle 2 of a write to index 7 (old 0x55…) → outputs go to 0 next cycle, and a later read of index 7 returns 0x55….
- Aliasing: write to 0x4010, read 0x0010 (DEPTH_LOG2=10) → returns the same block.
